// File: rtl/reg_bank_queued_if.sv
// Register-bank datapath bundle: op/write/load inputs from the pipeline and read/status outputs.
// The master side drives the operation inputs and the slave side (the register bank) drives the read and status outputs.
interface reg_bank_queued_if #(
  parameter int REG_WIDTH  = 32,
  parameter int IDX_WIDTH  = 4,
  parameter int ADDR_WIDTH = 14
);
  logic                  enable;
  logic                  privileged_mode;
  logic [2:0]            op;
  logic [IDX_WIDTH-1:0]  rs_a;
  logic [IDX_WIDTH-1:0]  rs_b;
  logic [IDX_WIDTH-1:0]  rd;
  logic [REG_WIDTH-1:0]  alu_result;
  logic [REG_WIDTH-1:0]  new_sp;
  logic [ADDR_WIDTH-1:0] new_pc;
  logic [REG_WIDTH-1:0]  load_data;
  logic                  load_valid;
  logic [REG_WIDTH-1:0]  read_data_a;
  logic [REG_WIDTH-1:0]  read_data_b;
  logic [REG_WIDTH-1:0]  store_data;
  logic [REG_WIDTH-1:0]  current_pc;
  logic [REG_WIDTH-1:0]  current_sp;
  logic                  pending_hazard;
  logic                  load_queue_full;
  logic                  load_queue_empty;
  logic                  load_error;

  modport master (
    output enable, privileged_mode, op, rs_a, rs_b, rd, alu_result, new_sp, new_pc,
           load_data, load_valid,
    input  read_data_a, read_data_b, store_data, current_pc, current_sp, pending_hazard,
           load_queue_full, load_queue_empty, load_error
  );

  modport slave (
    input  enable, privileged_mode, op, rs_a, rs_b, rd, alu_result, new_sp, new_pc,
           load_data, load_valid,
    output read_data_a, read_data_b, store_data, current_pc, current_sp, pending_hazard,
           load_queue_full, load_queue_empty, load_error
  );
endinterface

// File: rtl/reg_bank_queued.sv
// Register bank with banked SP, PC, and an in-order queue of pending load destinations
// used for RAW hazard detection and load retirement.
module reg_bank_queued #(
  parameter int REG_WIDTH       = 32,
  parameter int NUM_REGS        = 16,
  parameter int IDX_WIDTH       = 4,
  parameter int ADDR_WIDTH      = 14,
  parameter int DATA_AREA_START = 8192,
  parameter int RESET_PC        = 1,
  parameter int LOAD_DEPTH      = 4
) (
  input logic               clock,
  input logic               reset,
  reg_bank_queued_if.slave  bus
);
  localparam int QP_W   = $clog2(LOAD_DEPTH);
  localparam int PTR_W  = QP_W + 1;
  localparam int LR_IDX = NUM_REGS - 3;

  localparam logic [IDX_WIDTH-1:0]  PC_SEL  = IDX_WIDTH'(NUM_REGS - 1);
  localparam logic [IDX_WIDTH-1:0]  SP_SEL  = IDX_WIDTH'(NUM_REGS - 2);
  localparam logic [REG_WIDTH-1:0]  ONES    = {REG_WIDTH{1'b1}};
  localparam logic [REG_WIDTH-1:0]  R0_INIT = REG_WIDTH'(DATA_AREA_START);
  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

  localparam logic [2:0] OP_ALU    = 3'd1;
  localparam logic [2:0] OP_REINIT = 3'd2;
  localparam logic [2:0] OP_LOAD   = 3'd3;
  localparam logic [2:0] OP_TRAP   = 3'd4;
  localparam logic [2:0] OP_LDD    = 3'd6;

  logic [REG_WIDTH-1:0]  regs_r [NUM_REGS];
  logic [REG_WIDTH-1:0]  sp_user_r;
  logic [REG_WIDTH-1:0]  sp_priv_r;
  logic [ADDR_WIDTH-1:0] pc_r;
  logic [IDX_WIDTH-1:0]  q_mem_r [LOAD_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic                  load_error_r;

  logic [REG_WIDTH-1:0]  active_sp_s;
  logic [REG_WIDTH-1:0]  pc_ext_s;
  logic [REG_WIDTH-1:0]  wr_data_s;
  logic [REG_WIDTH-1:0]  sp_next_s;
  logic [PTR_W-1:0]      q_count_s;
  logic [IDX_WIDTH-1:0]  head_idx_s;
  logic                  q_empty_s;
  logic                  q_full_s;
  logic                  rd_ok_s;
  logic                  op_wr_s;
  logic                  load_req_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  err_set_s;
  logic                  uses_rd_s;
  logic                  hazard_s;

  // SP index aliases the active SP bank and PC index reads the zero-extended PC.
  function automatic logic [REG_WIDTH-1:0] map_read(
    input logic [IDX_WIDTH-1:0] idx,
    input logic [REG_WIDTH-1:0] gpr,
    input logic [REG_WIDTH-1:0] sp,
    input logic [REG_WIDTH-1:0] pc
  );
    if (idx == PC_SEL)      map_read = pc;
    else if (idx == SP_SEL) map_read = sp;
    else                    map_read = gpr;
  endfunction

  assign active_sp_s = bus.privileged_mode ? sp_priv_r : sp_user_r;
  assign pc_ext_s    = REG_WIDTH'(pc_r);
  assign wr_data_s   = (bus.op == OP_LDD) ? bus.load_data : bus.alu_result;
  assign sp_next_s   = (bus.op == OP_REINIT) ? ONES : bus.new_sp;

  assign q_count_s  = wr_ptr_r - rd_ptr_r;
  assign q_empty_s  = (wr_ptr_r == rd_ptr_r);
  assign q_full_s   = (wr_ptr_r[QP_W] != rd_ptr_r[QP_W]) &&
                      (wr_ptr_r[QP_W-1:0] == rd_ptr_r[QP_W-1:0]);
  assign head_idx_s = q_mem_r[rd_ptr_r[QP_W-1:0]];

  assign rd_ok_s    = (bus.rd != PC_SEL) && (bus.rd != SP_SEL);
  assign op_wr_s    = bus.enable && ((bus.op == OP_ALU) || (bus.op == OP_LDD)) && rd_ok_s;
  assign load_req_s = bus.enable && (bus.op == OP_LOAD);
  assign pop_s      = bus.load_valid && !q_empty_s;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push_s     = load_req_s && rd_ok_s && (!q_full_s || pop_s);
  assign err_set_s  = (load_req_s && !push_s) || (bus.load_valid && q_empty_s);
  assign uses_rd_s  = (bus.op == OP_ALU) || (bus.op == OP_LOAD) || (bus.op == OP_LDD);

  // Compare every occupied queue slot against the current source/destination indices.
  always_comb begin
    hazard_s = 1'b0;
    for (int k = 0; k < LOAD_DEPTH; k++) begin
      hazard_s = hazard_s | ((PTR_W'(k) < q_count_s) && (
        (q_mem_r[QP_W'(rd_ptr_r[QP_W-1:0] + QP_W'(k))] == bus.rs_a) ||
        (q_mem_r[QP_W'(rd_ptr_r[QP_W-1:0] + QP_W'(k))] == bus.rs_b) ||
        (uses_rd_s && (q_mem_r[QP_W'(rd_ptr_r[QP_W-1:0] + QP_W'(k))] == bus.rd))));
    end
  end

  // General registers; later assignments give the op write priority over retirement.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= (i == 0) ? R0_INIT : {REG_WIDTH{1'b0}};
      end
    end else begin
      if (pop_s) regs_r[head_idx_s] <= bus.load_data;
      if (op_wr_s) regs_r[bus.rd] <= wr_data_s;
      if (bus.enable && (bus.op == OP_REINIT)) regs_r[0] <= R0_INIT;
      if (bus.enable && (bus.op == OP_TRAP)) regs_r[LR_IDX] <= pc_ext_s;
    end
  end

  // PC and the two SP banks; only the active bank follows new_sp.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_r      <= PC_INIT;
      sp_user_r <= ONES;
      sp_priv_r <= ONES;
    end else if (bus.enable) begin
      pc_r <= bus.new_pc;
      if (bus.privileged_mode) sp_priv_r <= sp_next_s;
      else                     sp_user_r <= sp_next_s;
    end
  end

  // Load-destination queue pointers, storage and the sticky error flag.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      load_error_r <= 1'b0;
      for (int i = 0; i < LOAD_DEPTH; i++) begin
        q_mem_r[i] <= {IDX_WIDTH{1'b0}};
      end
    end else begin
      if (push_s) begin
        q_mem_r[wr_ptr_r[QP_W-1:0]] <= bus.rd;
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      if (err_set_s) load_error_r <= 1'b1;
    end
  end

  assign bus.read_data_a      = map_read(bus.rs_a, regs_r[bus.rs_a], active_sp_s, pc_ext_s);
  assign bus.read_data_b      = map_read(bus.rs_b, regs_r[bus.rs_b], active_sp_s, pc_ext_s);
  assign bus.store_data       = map_read(bus.rd, regs_r[bus.rd], active_sp_s, pc_ext_s);
  assign bus.current_pc       = pc_ext_s;
  assign bus.current_sp       = active_sp_s;
  assign bus.pending_hazard   = hazard_s;
  assign bus.load_queue_full  = q_full_s;
  assign bus.load_queue_empty = q_empty_s;
  assign bus.load_error       = load_error_r;
endmodule

// File: doc/reg_bank_queued.md
Name: reg_bank_queued

Overview:
Parametrised register bank with two read ports, a banked user/privileged stack pointer, and a PC register. It supports up to LOAD_DEPTH outstanding memory loads through an in-order load-destination queue, retired by a load_valid handshake. It sits between decode, ALU and memory-interface stages, and flags RAW hazards on registers with pending loads so the control unit can stall.

Parameters:
REG_WIDTH, 32, data width of every register
NUM_REGS, 16, architectural registers; index NUM_REGS-1 = PC, NUM_REGS-2 = SP, NUM_REGS-3 = LR
IDX_WIDTH, 4, register index width (log2 NUM_REGS)
ADDR_WIDTH, 14, PC width; PC is zero-extended to REG_WIDTH
DATA_AREA_START, 8192, reset/reinit value of R0
RESET_PC, 1, PC value after reset
LOAD_DEPTH, 4, max outstanding loads (power of two, ≥2)

Ports:
clock  in  1  sole clock; all state updates on posedge
reset  in  1  asynchronous, active-low
enable  in  1  qualifies op, PC update and SP update
privileged_mode  in  1  selects privileged SP bank (1) or user SP bank (0)
op  in  3  0 NOP, 1 RD=alu_result, 2 stack/R0 reinit, 3 issue load, 4 trap (LR=PC), 5 NOP, 6 RD=load_data direct
rs_a, rs_b, rd  in  IDX_WIDTH  source and destination indices
alu_result  in  REG_WIDTH  write data for op 1
new_sp  in  REG_WIDTH  next SP for the active bank
new_pc  in  ADDR_WIDTH  next PC
load_data  in  REG_WIDTH  memory return data
load_valid  in  1  one-cycle pulse: load_data belongs to the queue head
read_data_a, read_data_b  out  REG_WIDTH  combinational reads; SP index maps to the active SP bank
store_data  out  REG_WIDTH  combinational read of rd (SP-mapped)
current_pc, current_sp  out  REG_WIDTH  PC; active-bank SP
pending_hazard  out  1  combinational
load_queue_full, load_queue_empty  out  1  queue status
load_error  out  1  sticky

Behaviour:
- Reset (async, reset=0):
  - R0=DATA_AREA_START; both SP banks all-ones; PC=RESET_PC; all other registers 0.
  - Queue empty; load_error=0.
  - Outputs follow these values immediately. On reset mid-operation, outstanding loads are discarded.
- Enabled cycle:
  - PC <= {0, new_pc}.
  - Active SP bank <= all-ones if op==2, else new_sp. The inactive bank is untouched.
  - op 1/6: write rd only if rd is not PC or SP (silently dropped otherwise); LR is writable.
  - op 2: R0 <= DATA_AREA_START.
  - op 4: LR <= current PC, i.e. the pre-update value.
  - op 3: push rd into the queue if rd is not PC/SP and the queue is not full (or a pop occurs the same cycle). Otherwise the op is dropped and load_error is set.
- enable=0: no PC, SP or op effects. Load retirement still proceeds.
- Retirement (independent of enable):
  - load_valid with queue non-empty: head register <= load_data, queue pops.
  - load_valid with queue empty: ignored, load_error <= 1.
- Write priority when an op-1/6 write and a retirement target the same register in the same cycle: the op write wins (it is younger in program order).
- Push and pop in the same cycle: both take effect; occupancy is unchanged; legal when full.
- pending_hazard=1 when any valid queue entry matches rs_a, rs_b, or rd (when op∈{1,3,6}). It is purely combinational and does not gate writes; the control unit must hold enable=0.
- Reads have no bypass: they return pre-edge register contents.
- Queue pointers are IDX-agnostic and use wrap-around indices of width log2(LOAD_DEPTH)+1.
- Latency: a write is visible on read ports the cycle after its posedge. A load completes one cycle after load_valid.

Test Plan:
1. Release reset -> R0=8192, current_sp=0xFFFFFFFF, current_pc=1, empty=1, error=0; assert reset mid-queue with 2 loads pending -> empty=1 immediately.
2. enable=1, op=1, rd=3, alu_result=0xA5, new_pc=7 -> next cycle read R3=0xA5, current_pc=7; same op with rd=15 -> PC=new_pc, R15 not overwritten by 0xA5.
3. privileged_mode=1, new_sp=0x100 -> current_sp=0x100; drop privileged_mode -> current_sp=0xFFFFFFFF (user bank untouched); op=2 -> active SP=0xFFFFFFFF, R0=8192.
4. Issue loads to R2,R5,R7,R9 -> full=1; a fifth load -> dropped, load_error=1; load_valid with data 0x11,0x22 -> R2=0x11, R5=0x22 in order.
5. Load to R4 pending, rs_a=4 -> pending_hazard=1; same-cycle load_valid (0x55) and op=1 rd=4 alu 0x66 -> R4=0x66, queue empty.
6. Full queue with simultaneous push R6 and load_valid -> full stays 1, R6 retires last; op=4 with PC=0x20 -> LR=0x20.
